// File: rtl/pc_fetch_sequencer.sv
// Fetch front end that owns the architectural PC: fetches at CurrentPC over
// req/ack, presents the word over valid/ready, and commits NextPC on accept.
module pc_fetch_sequencer #(
  parameter int ADDR_W         = 64,
  parameter int INSTR_W        = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ALIGN_CHECK    = 0
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [ADDR_W-1:0]  StartPC,
  input  logic [ADDR_W-1:0]  NextPC,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic               Fault,
  output logic [31:0]        RetiredCount,
  output logic [1:0]         DbgState
);

  // Handshakes: IMemReq is held until a single-cycle IMemAck; InstrValid is
  // held with Instr stable until a cycle where InstrReady=1 (the transfer edge).

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [31:0]          retired_q, retired_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 misaligned;

  assign misaligned = (ALIGN_CHECK != 0) && (NextPC[1:0] != 2'b00);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= ST_INIT;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_INIT: begin
        pc_d    = StartPC;
        tmo_d   = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // An ack arriving on the expiry cycle still completes the fetch.
        if (IMemAck) begin
          instr_d = IMemData;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (InstrReady) begin
          if (misaligned) begin
            state_d = ST_FAULT;
          end else begin
            pc_d      = NextPC;
            retired_d = retired_q + 32'd1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign CurrentPC    = pc_q;
  assign IMemReq      = (state_q == ST_REQ);
  assign IMemAddr     = pc_q;
  assign Instr        = instr_q;
  assign InstrValid   = (state_q == ST_ISSUE);
  assign Fault        = (state_q == ST_FAULT);
  assign RetiredCount = retired_q;
  assign DbgState     = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: two instances (alignment check off/on) share
// stimulus and are compared each cycle against a transaction-level model.
module tb_pc_fetch_sequencer;

  localparam int TMO = 4;

  logic              CLK;
  logic              resetl;
  logic [63:0]       start_pc;
  logic [63:0]       next_pc;
  logic              ack;
  logic [31:0]       data;
  logic              ready;

  logic [1:0][63:0]  cur_pc;
  logic [1:0][63:0]  addr;
  logic [1:0][31:0]  instr;
  logic [1:0][31:0]  ret;
  logic [1:0][1:0]   dbg;
  logic [1:0]        req;
  logic [1:0]        valid;
  logic [1:0]        fault;

  int n_total = 0;
  int n_bad   = 0;

  // Model: per instance, whether the boot load happened, whether a word is
  // being offered downstream, whether it died, and unacked request cycles.
  logic [63:0] m_pc      [2];
  logic [31:0] m_instr   [2];
  logic [31:0] m_ret     [2];
  bit          m_booted  [2];
  bit          m_holding [2];
  bit          m_dead    [2];
  int          m_wait    [2];
  bit          m_align   [2];

  logic [31:0] exp_q[$];

  pc_fetch_sequencer #(.ADDR_W(64), .INSTR_W(32), .TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(0)) u_a (
    .CLK(CLK), .resetl(resetl), .StartPC(start_pc), .NextPC(next_pc),
    .CurrentPC(cur_pc[0]), .IMemReq(req[0]), .IMemAddr(addr[0]),
    .IMemAck(ack), .IMemData(data), .Instr(instr[0]), .InstrValid(valid[0]),
    .InstrReady(ready), .Fault(fault[0]), .RetiredCount(ret[0]), .DbgState(dbg[0])
  );

  pc_fetch_sequencer #(.ADDR_W(64), .INSTR_W(32), .TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1)) u_b (
    .CLK(CLK), .resetl(resetl), .StartPC(start_pc), .NextPC(next_pc),
    .CurrentPC(cur_pc[1]), .IMemReq(req[1]), .IMemAddr(addr[1]),
    .IMemAck(ack), .IMemData(data), .Instr(instr[1]), .InstrValid(valid[1]),
    .InstrReady(ready), .Fault(fault[1]), .RetiredCount(ret[1]), .DbgState(dbg[1])
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_instr[i] = '0; m_ret[i] = '0;
      m_booted[i] = 0; m_holding[i] = 0; m_dead[i] = 0; m_wait[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_update(input int i);
    if (m_dead[i]) begin
      // terminal until reset
    end else if (!m_booted[i]) begin
      m_pc[i] = start_pc;
      m_booted[i] = 1;
    end else if (m_holding[i]) begin
      if (ready) begin
        if (m_align[i] && (next_pc[1:0] != 2'b00)) begin
          m_dead[i] = 1;
        end else begin
          m_pc[i] = next_pc;
          m_ret[i] = m_ret[i] + 32'd1;
          m_holding[i] = 0;
        end
      end
    end else if (ack) begin
      m_instr[i] = data;
      m_holding[i] = 1;
      m_wait[i] = 0;
      if (i == 0) exp_q.push_back(data);
    end else begin
      m_wait[i]++;
      if (m_wait[i] >= TMO) m_dead[i] = 1;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("pc%0d", i),    cur_pc[i], m_pc[i]);
      check_eq($sformatf("addr%0d", i),  addr[i],   m_pc[i]);
      check_eq($sformatf("req%0d", i),   req[i],    m_booted[i] && !m_holding[i] && !m_dead[i]);
      check_eq($sformatf("valid%0d", i), valid[i],  m_holding[i] && !m_dead[i]);
      check_eq($sformatf("fault%0d", i), fault[i],  m_dead[i]);
      check_eq($sformatf("instr%0d", i), instr[i],  m_instr[i]);
      check_eq($sformatf("ret%0d", i),   ret[i],    m_ret[i]);
    end
  endtask

  // One clock: scoreboard the downstream transfer, advance model, compare.
  task automatic step();
    if (resetl && valid[0] && ready) begin
      check_eq("acc_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check_eq("acc_instr", instr[0], exp_q.pop_front());
    end
    @(posedge CLK);
    if (!resetl) model_reset();
    else for (int i = 0; i < 2; i++) model_update(i);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    step();
    resetl = 1'b1;
    step();
  endtask

  initial begin
    m_align[0] = 0;
    m_align[1] = 1;
    resetl = 1'b0; start_pc = 64'h40; next_pc = '0;
    ack = 1'b0; data = '0; ready = 1'b0;
    model_reset();
    #1;

    // Reset state
    repeat (2) step();
    check_eq("rst_pc", cur_pc[0], 64'h0);
    check_eq("rst_req", req[0], 1'b0);
    check_eq("rst_ret", ret[0], 32'h0);

    // Boot load then first request
    resetl = 1'b1;
    step();
    check_eq("boot_pc", cur_pc[0], 64'h40);
    check_eq("boot_req", req[0], 1'b1);
    check_eq("boot_addr", addr[0], 64'h40);

    // Zero-wait sequential fetch
    ack = 1'b1; data = 32'h8B020020; ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_pc = m_pc[0] + 64'd4;
      step();
    end
    check_eq("seq_ret", ret[0], 32'd3);
    check_eq("seq_pc", cur_pc[0], 64'h4C);

    // Backpressure then branch commit of a misaligned target
    ready = 1'b0;
    step();
    ack = 1'b0; next_pc = 64'h2A;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_instr", instr[0], 32'h8B020020);
      check_eq("bp_pc", cur_pc[0], 64'h4C);
    end
    ready = 1'b1;
    step();
    check_eq("br_pc", cur_pc[0], 64'h2A);
    check_eq("br_addr", addr[0], 64'h2A);
    check_eq("br_ret", ret[0], 32'd4);
    check_eq("mis_fault", fault[1], 1'b1);
    check_eq("mis_pc", cur_pc[1], 64'h4C);
    check_eq("mis_ret", ret[1], 32'd3);

    // Wait-state memory: ack on the last allowed request cycle
    ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("ws_req", req[0], 1'b1);
      check_eq("ws_addr", addr[0], 64'h40);
    end
    ack = 1'b1; data = 32'h12345678;
    step();
    check_eq("ws_instr", instr[0], 32'h12345678);
    check_eq("ws_valid", valid[0], 1'b1);
    check_eq("ws_fault", fault[0], 1'b0);

    // Timeout, then a late ack is ignored
    ack = 1'b0; ready = 1'b1; next_pc = 64'h50;
    step();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_eq("tmo_early", fault[0], 1'b0);
    step();
    check_eq("tmo_fault", fault[0], 1'b1);
    check_eq("tmo_req", req[0], 1'b0);
    ack = 1'b1; ready = 1'b1;
    repeat (3) step();
    check_eq("tmo_sticky", fault[0], 1'b1);
    check_eq("tmo_valid", valid[0], 1'b0);

    // Asynchronous reset in the middle of a request
    ack = 1'b0; ready = 1'b0;
    do_reset();
    #2;
    resetl = 1'b0;
    #1;
    model_reset();
    check_eq("arst_req", req[0], 1'b0);
    check_eq("arst_pc", cur_pc[0], 64'h0);
    compare_all();
    ack = 1'b1; data = 32'hDEADBEEF;
    repeat (2) step();
    ack = 1'b0;
    resetl = 1'b1;
    step();
    check_eq("arst_boot", cur_pc[0], 64'h40);

    // Randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      start_pc = {$urandom, $urandom} & ~64'h3;
      do_reset();
      for (int k = 0; k < 50; k++) begin
        ack   = ($urandom_range(0, 99) < 70);
        data  = $urandom;
        ready = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 9) == 0) next_pc = {$urandom, $urandom};
        else next_pc = m_pc[0] + 64'd4;
        resetl = ($urandom_range(0, 199) != 0);
        step();
        resetl = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle fetch front end that owns the architectural program counter. Holds CurrentPC, which feeds the next-PC logic. Fetches the instruction at CurrentPC from instruction memory over a req/ack handshake and presents it downstream over a valid/ready handshake. When the instruction is accepted, it commits the NextPC value returned by the next-PC logic.

Parameters:
ADDR_W, 64, PC / memory address width
INSTR_W, 32, instruction width
TIMEOUT_CYCLES, 16, REQ cycles without IMemAck before FAULT (legal range 1..255)
ALIGN_CHECK, 0, when 1, NextPC[1:0]!=0 at commit enters FAULT

Ports:
CLK  input  1  clock, all state updates on rising edge
resetl  input  1  asynchronous active-low reset
StartPC  input  ADDR_W  PC loaded on first clock after reset release
NextPC  input  ADDR_W  from next-PC logic, combinational on CurrentPC/branch inputs
CurrentPC  output  ADDR_W  registered architectural PC
IMemReq  output  1  fetch request
IMemAddr  output  ADDR_W  fetch address, equals CurrentPC while IMemReq=1
IMemAck  input  1  memory response valid, single-cycle pulse
IMemData  input  INSTR_W  instruction word, valid with IMemAck
Instr  output  INSTR_W  held fetched instruction
InstrValid  output  1  Instr valid for downstream
InstrReady  input  1  downstream accepts Instr
Fault  output  1  sticky fetch fault (timeout or misalignment)
RetiredCount  output  32  count of accepted instructions

Behaviour:
- Async reset (resetl=0): state=INIT; CurrentPC=0; Instr=0; IMemReq=0; InstrValid=0; Fault=0; RetiredCount=0; timeout counter=0. Reset asserted mid-operation aborts any pending fetch immediately. A late IMemAck after reset is ignored.
- States: INIT, REQ, ISSUE, FAULT. Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- INIT: one cycle. CurrentPC<=StartPC; go to REQ.
- REQ: IMemReq=1, IMemAddr=CurrentPC.
  - If IMemAck=1: Instr<=IMemData, timeout counter cleared, go to ISSUE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT_CYCLES-1 in a no-ack cycle: Fault<=1, go to FAULT.
  - An ack in the same cycle the counter would expire wins (the fetch succeeds).
- ISSUE: InstrValid=1, Instr stable, IMemReq=0.
  - If InstrReady=1: CurrentPC<=NextPC (value sampled that edge), RetiredCount<=RetiredCount+1 (wraps modulo 2^32), go to REQ.
  - If ALIGN_CHECK=1 and NextPC[1:0]!=0: Fault<=1, go to FAULT. CurrentPC and RetiredCount are not updated.
  - If InstrReady=0: hold indefinitely with no timeout.
- FAULT: terminal until reset. IMemReq=0, InstrValid=0, CurrentPC frozen, Fault=1.
- Minimum latency with zero-wait memory (ack in first REQ cycle) and InstrReady held 1: one instruction per 2 cycles (REQ, ISSUE).
- IMemAck outside REQ is ignored.
- CurrentPC arithmetic is performed only by the next-PC logic. This block never adds. NextPC wraps naturally at ADDR_W bits.
- ALIGN_CHECK=0: any NextPC value, including odd ones, is committed verbatim.

Test Plan:
- Reset/start: hold resetl=0 with StartPC=0x40 → all outputs 0. Release reset → CurrentPC=0x40 after 1 clock; IMemReq=1 with IMemAddr=0x40 on the next cycle.
- Sequential fetch: ack in first REQ cycle with IMemData=0x8B020020; InstrReady=1; NextPC=CurrentPC+4 → InstrValid pulses every 2nd cycle; CurrentPC goes 0x40, 0x44, 0x48; RetiredCount=3 after 3 handshakes.
- Branch commit / backpressure: in ISSUE, hold InstrReady=0 for 5 cycles with NextPC=0x2A, then raise InstrReady → Instr and CurrentPC stable for all 5 cycles. CurrentPC=0x2A after the handshake. Next IMemAddr=0x2A (ALIGN_CHECK=0).
- Wait-state memory: ack delayed 3 cycles → IMemReq held 4 cycles at a constant address; Instr captures the data on the ack edge; Fault=0.
- Timeout: TIMEOUT_CYCLES=4, never ack → Fault=1 after 4 REQ cycles; IMemReq=0; a later IMemAck is ignored; Fault stays 1 until resetl=0.
- Misalign and mid-fetch reset: ALIGN_CHECK=1 with NextPC=0x46 at handshake → FAULT; CurrentPC is unchanged and RetiredCount is not incremented. Separately, assert resetl=0 mid-REQ → outputs clear asynchronously without waiting for a clock edge.
